laser_host: RTL and testbench

LASER_HOST -- requirements
Module: laser_host

---
 rtl/laser_host.sv | 163 ++++++++++++++++
 tb/tb_laser_host.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_host.sv
// laser_host: job sequencer in front of the two-circle laser engine.
// Holds an N_OBJ-entry point pattern, streams it to the engine after a
// reset pulse, waits for the engine's two centres (or gives up after
// TIMEOUT_CYC cycles), then counts how many stored points either circle
// covers and reports the result with a one-cycle VALID pulse.
module laser_host #(
  parameter int N_OBJ       = 40,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LD_EN,
  input  logic [5:0] LD_ADDR,
  input  logic [3:0] LD_X,
  input  logic [3:0] LD_Y,
  input  logic       START,
  output logic       BUSY,
  output logic       LASER_RST,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic [7:0] RES_C1,
  output logic [7:0] RES_C2,
  output logic [5:0] COVER,
  output logic       VALID,
  output logic       TIMEOUT
);

  // Wait counter only needs to reach TIMEOUT_CYC-1.
  localparam int WCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);
  localparam logic [5:0]     LAST_IDX  = 6'(N_OBJ - 1);

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    SEND,
    WAIT,
    SCORE,
    REPORT
  } state_t;

  state_t         state;
  logic [7:0]     mem [N_OBJ];
  logic [5:0]     idx;
  logic [5:0]     next_idx;
  logic [WCW-1:0] wait_cnt;
  logic [7:0]     score_pt;
  logic           score_hit;

  // Diamond of radius 4 plus the (2,3)/(3,2) corners approximates a circle.
  function automatic logic is_inside(input logic [7:0] pt, input logic [7:0] ctr);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [4:0] sum;
    dx  = (pt[3:0] >= ctr[3:0]) ? (pt[3:0] - ctr[3:0]) : (ctr[3:0] - pt[3:0]);
    dy  = (pt[7:4] >= ctr[7:4]) ? (pt[7:4] - ctr[7:4]) : (ctr[7:4] - pt[7:4]);
    sum = {1'b0, dx} + {1'b0, dy};
    return (sum <= 5'd4) || (dx == 4'd2 && dy == 4'd3) || (dx == 4'd3 && dy == 4'd2);
  endfunction

  // Current scoring candidate and whether either captured circle covers it.
  always_comb begin
    next_idx  = idx + 6'd1;
    score_pt  = mem[idx];
    score_hit = is_inside(score_pt, RES_C1) || is_inside(score_pt, RES_C2);
  end

  // Pattern memory: writable only while idle, including the START cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_OBJ; i++) mem[i] <= '0;
    end else if (state == IDLE && LD_EN && ({1'b0, LD_ADDR} < 7'(N_OBJ))) begin
      mem[LD_ADDR] <= {LD_Y, LD_X};
    end
  end

  // Job sequencer; every output is a register updated here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      BUSY      <= 1'b0;
      LASER_RST <= 1'b0;
      X         <= '0;
      Y         <= '0;
      RES_C1    <= '0;
      RES_C2    <= '0;
      COVER     <= '0;
      VALID     <= 1'b0;
      TIMEOUT   <= 1'b0;
      idx       <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state     <= KICK;
            BUSY      <= 1'b1;
            LASER_RST <= 1'b1;
            COVER     <= '0;
          end
        end
        KICK: begin
          LASER_RST <= 1'b0;
          X         <= mem[0][3:0];
          Y         <= mem[0][7:4];
          idx       <= '0;
          state     <= SEND;
        end
        SEND: begin
          if (idx == LAST_IDX) begin
            X        <= '0;
            Y        <= '0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            idx <= next_idx;
            X   <= mem[next_idx][3:0];
            Y   <= mem[next_idx][7:4];
          end
        end
        WAIT: begin
          if (DONE) begin
            RES_C1 <= {C1Y, C1X};
            RES_C2 <= {C2Y, C2X};
            idx    <= '0;
            state  <= SCORE;
          end else if (wait_cnt == WAIT_LAST) begin
            RES_C1  <= '0;
            RES_C2  <= '0;
            COVER   <= '0;
            TIMEOUT <= 1'b1;
            VALID   <= 1'b1;
            state   <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        SCORE: begin
          if (score_hit) COVER <= COVER + 6'd1;
          if (idx == LAST_IDX) begin
            VALID <= 1'b1;
            state <= REPORT;
          end else begin
            idx <= next_idx;
          end
        end
        REPORT: begin
          VALID   <= 1'b0;
          TIMEOUT <= 1'b0;
          BUSY    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// tb_laser_host: scenario tasks driving laser_host and comparing against a
// point-list model that applies the coverage rule with plain integer math.
module tb_laser_host;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       LD_EN = 1'b0;
  logic [5:0] LD_ADDR = '0;
  logic [3:0] LD_X = '0, LD_Y = '0;
  logic       START = 1'b0;
  logic       BUSY, LASER_RST;
  logic [3:0] X, Y;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic       DONE = 1'b0;
  logic [7:0] RES_C1, RES_C2;
  logic [5:0] COVER;
  logic       VALID, TIMEOUT;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem_model [40];

  int         lr_count, lr_first, valid_cyc, valid_count;
  logic [7:0] xy_hist [256];
  logic [5:0] obs_cover, cover_start;
  logic [7:0] obs_res1, obs_res2;
  logic       obs_timeout, valid_next, busy_next, busy_start;

  laser_host #(.N_OBJ(40), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .LD_EN(LD_EN), .LD_ADDR(LD_ADDR),
    .LD_X(LD_X), .LD_Y(LD_Y), .START(START), .BUSY(BUSY),
    .LASER_RST(LASER_RST), .X(X), .Y(Y), .C1X(C1X), .C1Y(C1Y),
    .C2X(C2X), .C2Y(C2Y), .DONE(DONE), .RES_C1(RES_C1), .RES_C2(RES_C2),
    .COVER(COVER), .VALID(VALID), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit near(int px, int py, int cx, int cy);
    int dx = (px > cx) ? px - cx : cx - px;
    int dy = (py > cy) ? py - cy : cy - py;
    return (dx + dy <= 4) || (dx == 2 && dy == 3) || (dx == 3 && dy == 2);
  endfunction

  function automatic int model_cover(int c1x, int c1y, int c2x, int c2y);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      int px = int'(mem_model[i][3:0]);
      int py = int'(mem_model[i][7:4]);
      if (near(px, py, c1x, c1y) || near(px, py, c2x, c2y)) n++;
    end
    return n;
  endfunction

  task automatic write_point(input int addr, input int x, input int y);
    LD_EN = 1'b1; LD_ADDR = 6'(addr); LD_X = 4'(x); LD_Y = 4'(y);
    tick();
    LD_EN = 1'b0;
    if (addr < 40) mem_model[addr] = {4'(y), 4'(x)};
  endtask

  task automatic clear_model();
    for (int i = 0; i < 40; i++) mem_model[i] = 8'h00;
  endtask

  task automatic sample_cycle(input int cyc);
    if (LASER_RST) begin
      lr_count++;
      if (lr_first < 0) lr_first = cyc;
    end
    xy_hist[cyc] = {Y, X};
    if (VALID) begin
      valid_count++;
      if (valid_cyc < 0) begin
        valid_cyc = cyc; obs_cover = COVER; obs_res1 = RES_C1;
        obs_res2 = RES_C2; obs_timeout = TIMEOUT;
      end
    end
  endtask

  // Edge 1 accepts START; DONE is held high only for the edge numbered done_at.
  task automatic run_job(input int c1x, input int c1y, input int c2x, input int c2y,
                         input int done_at, input bit noise);
    int cyc;
    lr_count = 0; lr_first = -1; valid_cyc = -1; valid_count = 0;
    obs_cover = '0; obs_res1 = '0; obs_res2 = '0; obs_timeout = 1'b0;
    C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
    START = 1'b1;
    tick();
    START = 1'b0; LD_EN = 1'b0;
    cyc = 1;
    busy_start = BUSY; cover_start = COVER;
    sample_cycle(cyc);
    while (cyc < 150 && valid_cyc < 0) begin
      DONE = (cyc + 1 == done_at);
      if (noise) begin
        START = (cyc + 1 == 10) || (cyc + 1 == 50);
        LD_EN = (cyc + 1 == 30); LD_ADDR = 6'd0;
        LD_X = 4'($urandom); LD_Y = 4'($urandom);
        if (cyc + 1 == 20) begin
          DONE = 1'b1;
          C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
        end else begin
          C1X = 4'(c1x); C1Y = 4'(c1y); C2X = 4'(c2x); C2Y = 4'(c2y);
        end
      end
      tick();
      cyc++;
      sample_cycle(cyc);
    end
    DONE = 1'b0; START = 1'b0; LD_EN = 1'b0;
    tick();
    valid_next = VALID; busy_next = BUSY;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    tests_run++;
    if ({BUSY, LASER_RST, X, Y, RES_C1, RES_C2, COVER, VALID, TIMEOUT} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b rst=%b x=%0d y=%0d c1=%h c2=%h cov=%0d v=%b t=%b, expected all 0",
               BUSY, LASER_RST, X, Y, RES_C1, RES_C2, COVER, VALID, TIMEOUT);
    end
    RST_N = 1'b1;
    clear_model();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if ({BUSY, LASER_RST, X, Y, RES_C1, RES_C2, COVER, VALID, TIMEOUT} !== '0) begin
        tests_failed++;
        $display("[TB] FAIL idle_outputs cycle %0d: got busy=%b cov=%0d v=%b x=%0d, expected all 0",
                 i, BUSY, COVER, VALID, X);
      end
    end
  endtask

  task automatic test_uniform();
    for (int i = 0; i < 40; i++) write_point(i, 5, 5);
    run_job(5, 5, 0, 0, 46, 1'b0);
    tests_run++;
    if (lr_count != 1 || lr_first != 1) begin
      tests_failed++;
      $display("[TB] FAIL uniform_laser_rst: got %0d cycles first at %0d, expected 1 cycle at 1", lr_count, lr_first);
    end
    tests_run++;
    if (busy_start !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL uniform_busy: got %b expected 1", busy_start);
    end
    for (int k = 0; k < 40; k++) begin
      tests_run++;
      if (xy_hist[2 + k] !== 8'h55) begin
        tests_failed++;
        $display("[TB] FAIL uniform_send[%0d]: got %h expected 55", k, xy_hist[2 + k]);
      end
    end
    tests_run++;
    if (xy_hist[1] !== 8'h00 || xy_hist[42] !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL uniform_xy_idle: got kick=%h wait=%h expected 00 00", xy_hist[1], xy_hist[42]);
    end
    tests_run++;
    if (valid_cyc != 86 || valid_count != 1 || valid_next !== 1'b0 || busy_next !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL uniform_valid: got cyc=%0d cnt=%0d next=%b busy_next=%b expected 86 1 0 0",
               valid_cyc, valid_count, valid_next, busy_next);
    end
    tests_run++;
    if (obs_cover !== 6'd40 || obs_res1 !== 8'h55 || obs_res2 !== 8'h00 || obs_timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL uniform_result: got cov=%0d c1=%h c2=%h to=%b expected 40 55 00 0",
               obs_cover, obs_res1, obs_res2, obs_timeout);
    end
    repeat (5) tick();
    tests_run++;
    if (COVER !== 6'd40 || RES_C1 !== 8'h55 || VALID !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL uniform_hold: got cov=%0d c1=%h v=%b busy=%b expected 40 55 0 0", COVER, RES_C1, VALID, BUSY);
    end
  endtask

  task automatic test_split();
    for (int i = 0; i < 40; i++) write_point(i, (i < 20) ? 0 : 15, (i < 20) ? 0 : 15);
    run_job(0, 0, 15, 15, 50, 1'b0);
    tests_run++;
    if (obs_cover !== 6'd40 || obs_res2 !== 8'hff) begin
      tests_failed++;
      $display("[TB] FAIL split_both: got cov=%0d c2=%h expected 40 ff", obs_cover, obs_res2);
    end
    run_job(0, 0, 8, 8, 43, 1'b0);
    tests_run++;
    if (obs_cover !== 6'd20 || cover_start !== 6'd0 || valid_cyc != 83) begin
      tests_failed++;
      $display("[TB] FAIL split_one: got cov=%0d start_cov=%0d vcyc=%0d expected 20 0 83", obs_cover, cover_start, valid_cyc);
    end
  endtask

  task automatic test_diamond();
    for (int i = 0; i < 40; i++) write_point(i, 0, 15);
    write_point(3, 9, 10);
    write_point(11, 10, 9);
    write_point(17, 11, 7);
    write_point(25, 11, 8);
    write_point(39, 10, 10);
    run_job(7, 7, 7, 7, 58, 1'b0);
    tests_run++;
    if (obs_cover !== 6'd3 || obs_timeout !== 1'b0 || valid_cyc != 98) begin
      tests_failed++;
      $display("[TB] FAIL diamond_cover: got cov=%0d to=%b vcyc=%0d expected 3 0 98", obs_cover, obs_timeout, valid_cyc);
    end
  endtask

  task automatic test_timeout();
    run_job(3, 3, 4, 4, -1, 1'b0);
    tests_run++;
    if (valid_cyc != 58 || obs_timeout !== 1'b1 || valid_count != 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_timing: got vcyc=%0d to=%b cnt=%0d expected 58 1 1", valid_cyc, obs_timeout, valid_count);
    end
    tests_run++;
    if (obs_cover !== 6'd0 || obs_res1 !== 8'h00 || obs_res2 !== 8'h00 || TIMEOUT !== 1'b0 || busy_next !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_result: got cov=%0d c1=%h c2=%h to_after=%b busy=%b expected 0 00 00 0 0",
               obs_cover, obs_res1, obs_res2, TIMEOUT, busy_next);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      int c1x = $urandom_range(15), c1y = $urandom_range(15);
      int c2x = $urandom_range(15), c2y = $urandom_range(15);
      int d = (j == 0) ? 15 : $urandom_range(15);
      int exp_cov;
      for (int n = 0; n < 48; n++) write_point($urandom_range(63), $urandom_range(15), $urandom_range(15));
      LD_EN = 1'b1; LD_ADDR = 6'($urandom_range(39)); LD_X = 4'($urandom); LD_Y = 4'($urandom);
      mem_model[LD_ADDR] = {LD_Y, LD_X};
      exp_cov = model_cover(c1x, c1y, c2x, c2y);
      run_job(c1x, c1y, c2x, c2y, 43 + d, 1'b0);
      tests_run++;
      if (int'(obs_cover) != exp_cov || obs_res1 !== {4'(c1y), 4'(c1x)} || obs_res2 !== {4'(c2y), 4'(c2x)}) begin
        tests_failed++;
        $display("[TB] FAIL random_job%0d: got cov=%0d c1=%h c2=%h expected cov=%0d c1=%h c2=%h", j,
                 obs_cover, obs_res1, obs_res2, exp_cov, {4'(c1y), 4'(c1x)}, {4'(c2y), 4'(c2x)});
      end
      for (int k = 0; k < 40; k++) begin
        tests_run++;
        if (xy_hist[2 + k] !== mem_model[k]) begin
          tests_failed++;
          $display("[TB] FAIL random_send%0d[%0d]: got %h expected %h", j, k, xy_hist[2 + k], mem_model[k]);
        end
      end
      tests_run++;
      if (valid_cyc != 83 + d || obs_timeout !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL random_valid%0d: got cyc=%0d to=%b expected %0d 0", j, valid_cyc, obs_timeout, 83 + d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_cov;
    for (int i = 0; i < 40; i++) write_point(i, $urandom_range(15), $urandom_range(15));
    exp_cov = model_cover(4, 4, 11, 11);
    run_job(4, 4, 11, 11, 44, 1'b0);
    run_job(4, 4, 11, 11, 47, 1'b0);
    tests_run++;
    if (cover_start !== 6'd0 || busy_start !== 1'b1 || int'(obs_cover) != exp_cov || valid_cyc != 87) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back: got start_cov=%0d busy=%b cov=%0d vcyc=%0d expected 0 1 %0d 87",
               cover_start, busy_start, obs_cover, valid_cyc, exp_cov);
    end
  endtask

  task automatic test_noise_and_abort();
    int exp_cov;
    int vseen = 0;
    for (int i = 0; i < 40; i++) write_point(i, $urandom_range(1, 15), $urandom_range(15));
    exp_cov = model_cover(6, 9, 12, 2);
    run_job(6, 9, 12, 2, 45, 1'b1);
    tests_run++;
    if (int'(obs_cover) != exp_cov || obs_res1 !== 8'h96 || obs_res2 !== 8'h2c || valid_cyc != 85 || lr_count != 1) begin
      tests_failed++;
      $display("[TB] FAIL noise_job: got cov=%0d c1=%h c2=%h vcyc=%0d lr=%0d expected %0d 96 2c 85 1",
               obs_cover, obs_res1, obs_res2, valid_cyc, lr_count, exp_cov);
    end
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (11) tick();
    RST_N = 1'b0;
    #1;
    tests_run++;
    if ({BUSY, X, Y, COVER, RES_C1, VALID} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort_reset: got busy=%b x=%0d y=%0d cov=%0d c1=%h v=%b expected all 0",
               BUSY, X, Y, COVER, RES_C1, VALID);
    end
    clear_model();
    repeat (2) tick();
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (VALID) vseen++;
    end
    tests_run++;
    if (vseen != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", vseen);
    end
    exp_cov = model_cover(0, 0, 15, 15);
    run_job(0, 0, 15, 15, 50, 1'b0);
    tests_run++;
    if (int'(obs_cover) != exp_cov || valid_cyc != 90 || lr_count != 1) begin
      tests_failed++;
      $display("[TB] FAIL abort_fresh_job: got cov=%0d vcyc=%0d lr=%0d expected %0d 90 1",
               obs_cover, valid_cyc, lr_count, exp_cov);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_split();
    test_diamond();
    test_timeout();
    test_random();
    test_back_to_back();
    test_noise_and_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
